tracker_scheduler: RTL and testbench
====================================

# tracker_scheduler

Sequencing controller for the two-axis solar tracker. It takes one frame of four light-sensor ADC samples, decides which way each axis must turn, and drives the BTN_0/BTN_1 direction inputs of the horizontal and vertical `servo_driver` instances. Only one axis moves at a time, for a bounded dwell, followed by a settle period. It sits between the ADC sequencer and the two servo drivers.

## Interface
Parameters:
- ADC_W, 12: width of each light-sensor sample.
- DEADBAND, 64: minimum absolute sum difference that causes a move.
- MOVE_CYC, 100000: CLK cycles one move step lasts.
- SETTLE_CYC, 50000: CLK cycles of idle drive after each move.
- POS_MIN, 600: lower pulse-width limit in µs; ccw is suppressed at or below it.
- POS_MAX, 2400: upper pulse-width limit in µs; cw is suppressed at or above it.

Ports:
- CLK  in  1  system clock. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous, active-high reset.
- sample_valid  in  1  single-cycle pulse; all four ldr_* inputs are valid in that cycle.
- ldr_tl, ldr_tr, ldr_bl, ldr_br  in  ADC_W each  top-left, top-right, bottom-left and bottom-right samples.
- pos_h, pos_v  in  32 each  servo_position from the horizontal and vertical drivers.
- h_cw, h_ccw  out  1 each  horizontal driver BTN_0 / BTN_1.
- v_cw, v_ccw  out  1 each  vertical driver BTN_0 / BTN_1.
- busy  out  1  high in every state except IDLE.
- aligned  out  1  the last evaluation found both axes inside the deadband.
- state  out  3  current FSM state, for debug.

## Operation
- Capture: in IDLE, sample_valid registers all four samples. sample_valid is ignored in every other state.
- Sums (unsigned, ADC_W+1 bits):
  - L = tl + bl, R = tr + br
  - T = tl + tr, B = bl + br
- Differences: dH = R − L and dV = T − B, signed, ADC_W+2 bits, no saturation.
- Horizontal decision:
  - cw if dH > DEADBAND and pos_h < POS_MAX.
  - ccw if −dH > DEADBAND and pos_h > POS_MIN.
  - stop otherwise.
- Vertical decision: same rule, using dV and pos_v.
- States: IDLE, EVAL, MOVE_H, MOVE_V, SETTLE.
- IDLE → EVAL on sample_valid.
- EVAL (one cycle): register both decisions.
  - Go to MOVE_H if the horizontal decision is not stop.
  - Otherwise go to MOVE_V if the vertical decision is not stop.
  - Otherwise go to IDLE and set aligned = 1.
  - Any move clears aligned.
- MOVE_H / MOVE_V: assert the decided output for MOVE_CYC cycles, then go to SETTLE.
  - Early abort: if the moving axis reaches its limit (pos ≥ POS_MAX while cw, pos ≤ POS_MIN while ccw), go to SETTLE immediately.
- SETTLE: all outputs low for SETTLE_CYC cycles.
  - Then go to MOVE_V if a vertical move is still pending; otherwise go to IDLE.
  - The pending flag clears on entry to MOVE_V.
- Invariants:
  - At most one of h_cw, h_ccw, v_cw, v_ccw is high in any cycle.
  - The two axes never move simultaneously.

## Timing
- Reset values: state=IDLE, all direction outputs 0, busy 0, aligned 0, counter 0, pending flag 0, sample registers 0.
- RST asserted mid-move: outputs are low in the cycle after RST is sampled; the counter is cleared.
- Cycle 0: sample_valid high in IDLE. Cycle 1: EVAL. Cycle 2: first cycle the direction output is high.
- Outputs are registered. Move length is exactly MOVE_CYC cycles of high output.
- servo_driver adds one further register stage on direction.
- Limit abort: the output drops in the cycle after the limiting pos value is sampled.
- Settle length is exactly SETTLE_CYC cycles.
- A sample_valid arriving in the same cycle as the return to IDLE is ignored; the next pulse is accepted.
- busy rises in cycle 1 and falls in the first IDLE cycle.

## Structure
- Shared header `tracker_defs.vh`:
  - state encodings: IDLE=0, EVAL=1, MOVE_H=2, MOVE_V=3, SETTLE=4.
  - direction codes matching servo_driver: 00 stop, 01 cw, 10 ccw.
- Sub-module `dwell_counter`:
  - loadable down-counter with a `done` flag, 32 bits.
  - one instance, shared by move and settle.
- Arithmetic, decisions and the FSM live in the top module.

## Test plan
Bench parameters for all cases: DEADBAND=64, MOVE_CYC=8, SETTLE_CYC=4.

- Centered frame: tl=tr=bl=br=1000, pos_h=pos_v=1500, sample_valid pulse → no direction output high, aligned=1, busy high exactly cycle 1.
- Right brighter: tr=br=1100, tl=bl=1000 (dH=200) → h_cw high for exactly 8 cycles starting cycle 2, 4 settle cycles, then IDLE; v outputs stay 0.
- Both axes: tl=1200, others 1000 (dH=−200, dV=+200) → h_ccw high for 8 cycles, 4 settle cycles, v_cw high for 8 cycles, 4 settle cycles, IDLE; never two outputs high together.
- Limit abort: h_cw move with pos_h stepping to 2400 at move cycle 3 → h_cw low from the next cycle, SETTLE entered. If pos_h=2400 at EVAL → no horizontal move.
- Boundary: dH exactly 64 → stop. dH=65 → cw.
- Reset and retrigger: RST asserted mid-MOVE_V → all outputs 0 next cycle, state=IDLE. sample_valid pulses during SETTLE → ignored.

Source files
------------

// File: rtl/tracker_scheduler_pkg.sv
// Shared types for the solar tracker scheduler: FSM state codes, servo_driver
// direction codes and the axis limit check used while a move is in progress.
package tracker_scheduler_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_MOVE_H = 3'd2,
    ST_MOVE_V = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  // Bit 0 drives BTN_0 (cw), bit 1 drives BTN_1 (ccw) on servo_driver.
  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_CW   = 2'b01,
    DIR_CCW  = 2'b10
  } dir_t;

  function automatic logic at_limit(input dir_t dir, input logic [31:0] pos,
                                    input logic [31:0] pos_min,
                                    input logic [31:0] pos_max);
    return ((dir == DIR_CW) && (pos >= pos_max)) ||
           ((dir == DIR_CCW) && (pos <= pos_min));
  endfunction

endpackage

// File: rtl/tracker_scheduler_dwell_counter.sv
// Loadable 32-bit down-counter shared by the move and settle phases; done is
// high whenever the count has reached zero.
module dwell_counter
  import tracker_scheduler_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/tracker_scheduler.sv
// Two-axis solar tracker sequencer: evaluates one frame of four LDR samples and
// moves one axis at a time for a bounded dwell, each move followed by a settle.
module tracker_scheduler
  import tracker_scheduler_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int DEADBAND   = 64,
  parameter int MOVE_CYC   = 100000,
  parameter int SETTLE_CYC = 50000,
  parameter int POS_MIN    = 600,
  parameter int POS_MAX    = 2400
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] ldr_tl,
  input  logic [ADC_W-1:0] ldr_tr,
  input  logic [ADC_W-1:0] ldr_bl,
  input  logic [ADC_W-1:0] ldr_br,
  input  logic [31:0]      pos_h,
  input  logic [31:0]      pos_v,
  output logic             h_cw,
  output logic             h_ccw,
  output logic             v_cw,
  output logic             v_ccw,
  output logic             busy,
  output logic             aligned,
  output logic [2:0]       state
);

  localparam logic signed [ADC_W+1:0] DB_POS = (ADC_W+2)'(DEADBAND);
  localparam logic signed [ADC_W+1:0] DB_NEG = -DB_POS;
  localparam logic [31:0] P_MIN = 32'(POS_MIN);
  localparam logic [31:0] P_MAX = 32'(POS_MAX);
  // Counter runs load..0 inclusive, so load one less than the cycle count.
  localparam logic [CNT_W-1:0] MOVE_LOAD   = CNT_W'(MOVE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t                  fsm_state;
  logic [ADC_W-1:0]        s_tl, s_tr, s_bl, s_br;
  logic [ADC_W:0]          sum_l, sum_r, sum_t, sum_b;
  logic signed [ADC_W+1:0] d_h, d_v;
  dir_t                    dec_h, dec_v, dir_h_q, dir_v_q;
  logic                    move_any, v_pending, hit_h, hit_v;
  logic                    cnt_load, cnt_dec, cnt_done;
  logic [CNT_W-1:0]        cnt_val;

  assign sum_l = {1'b0, s_tl} + {1'b0, s_bl};
  assign sum_r = {1'b0, s_tr} + {1'b0, s_br};
  assign sum_t = {1'b0, s_tl} + {1'b0, s_tr};
  assign sum_b = {1'b0, s_bl} + {1'b0, s_br};
  assign d_h   = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
  assign d_v   = $signed({1'b0, sum_t}) - $signed({1'b0, sum_b});

  always_comb begin
    dec_h = DIR_STOP;
    dec_v = DIR_STOP;
    if ((d_h > DB_POS) && (pos_h < P_MAX))      dec_h = DIR_CW;
    else if ((d_h < DB_NEG) && (pos_h > P_MIN)) dec_h = DIR_CCW;
    if ((d_v > DB_POS) && (pos_v < P_MAX))      dec_v = DIR_CW;
    else if ((d_v < DB_NEG) && (pos_v > P_MIN)) dec_v = DIR_CCW;
  end

  assign move_any = (dec_h != DIR_STOP) || (dec_v != DIR_STOP);
  assign hit_h    = at_limit(dir_h_q, pos_h, P_MIN, P_MAX);
  assign hit_v    = at_limit(dir_v_q, pos_v, P_MIN, P_MAX);

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = MOVE_LOAD;
    case (fsm_state)
      ST_EVAL: cnt_load = move_any;
      ST_MOVE_H, ST_MOVE_V: begin
        if (cnt_done || ((fsm_state == ST_MOVE_H) ? hit_h : hit_v)) begin
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_done) cnt_load = v_pending;
        else          cnt_dec  = 1'b1;
      end
      default: ;
    endcase
  end

  dwell_counter u_dwell (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_state <= ST_IDLE;
      {h_cw, h_ccw, v_cw, v_ccw} <= 4'b0000;
      busy      <= 1'b0;
      aligned   <= 1'b0;
      v_pending <= 1'b0;
      dir_h_q   <= DIR_STOP;
      dir_v_q   <= DIR_STOP;
      {s_tl, s_tr, s_bl, s_br} <= '0;
    end else begin
      case (fsm_state)
        ST_IDLE: begin
          if (sample_valid) begin
            {s_tl, s_tr, s_bl, s_br} <= {ldr_tl, ldr_tr, ldr_bl, ldr_br};
            fsm_state <= ST_EVAL;
            busy      <= 1'b1;
          end
        end
        ST_EVAL: begin
          dir_h_q <= dec_h;
          dir_v_q <= dec_v;
          aligned <= !move_any;
          if (dec_h != DIR_STOP) begin
            fsm_state      <= ST_MOVE_H;
            {h_ccw, h_cw}  <= dec_h;
            v_pending      <= (dec_v != DIR_STOP);
          end else if (dec_v != DIR_STOP) begin
            fsm_state      <= ST_MOVE_V;
            {v_ccw, v_cw}  <= dec_v;
          end else begin
            fsm_state <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        ST_MOVE_H, ST_MOVE_V: begin
          if (cnt_done || ((fsm_state == ST_MOVE_H) ? hit_h : hit_v)) begin
            fsm_state <= ST_SETTLE;
            {h_cw, h_ccw, v_cw, v_ccw} <= 4'b0000;
          end
        end
        ST_SETTLE: begin
          if (cnt_done) begin
            if (v_pending) begin
              fsm_state     <= ST_MOVE_V;
              v_pending     <= 1'b0;
              {v_ccw, v_cw} <= dir_v_q;
            end else begin
              fsm_state <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: fsm_state <= ST_IDLE;
      endcase
    end
  end

  assign state = fsm_state;

endmodule

// File: tb/tb_tracker_scheduler.sv
// Self-checking bench for tracker_scheduler: table-driven frames plus hand-built
// corner sequences, with per-cycle expectations held in a scoreboard queue.
module tb_tracker_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] ldr_tl = '0, ldr_tr = '0, ldr_bl = '0, ldr_br = '0;
  logic [31:0] pos_h = 32'd1500, pos_v = 32'd1500;
  logic        h_cw, h_ccw, v_cw, v_ccw, busy, aligned;
  logic [2:0]  state;

  tracker_scheduler #(
    .ADC_W(12), .DEADBAND(64), .MOVE_CYC(8), .SETTLE_CYC(4),
    .POS_MIN(600), .POS_MAX(2400)
  ) dut (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid),
    .ldr_tl(ldr_tl), .ldr_tr(ldr_tr), .ldr_bl(ldr_bl), .ldr_br(ldr_br),
    .pos_h(pos_h), .pos_v(pos_v),
    .h_cw(h_cw), .h_ccw(h_ccw), .v_cw(v_cw), .v_ccw(v_ccw),
    .busy(busy), .aligned(aligned), .state(state)
  );

  always #5 CLK = ~CLK;

  // One expected observation per cycle; ca marks cycles where aligned is checked.
  typedef struct packed {
    logic [3:0] o;
    logic       b;
    logic [2:0] s;
    logic       ca;
    logic       al;
  } exp_t;

  typedef struct {
    logic [11:0] tl, tr, bl, br;
    logic [31:0] ph, pv;
    int          hd, vd;
    logic        al;
    string       name;
  } vec_t;

  exp_t  exp_q[$];
  vec_t  vecs[9];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string cur_name = "reset";

  task automatic push_entry(input logic [3:0] o, input logic b, input logic [2:0] s,
                            input logic ca, input logic al);
    exp_q.push_back('{o: o, b: b, s: s, ca: ca, al: al});
  endtask

  task automatic push_move(input int axis, input int dir, input int n);
    for (int i = 0; i < n; i++)
      push_entry(axis == 0 ? {dir == 1, dir == 2, 2'b00} : {2'b00, dir == 1, dir == 2},
                 1'b1, axis == 0 ? 3'd2 : 3'd3, 1'b0, 1'b0);
  endtask

  task automatic push_settle();
    for (int i = 0; i < 4; i++) push_entry(4'b0000, 1'b1, 3'd4, 1'b0, 1'b0);
  endtask

  // Cycle 0 is the sample_valid cycle; EVAL follows, then h move, v move, IDLE.
  task automatic push_timeline(input int hd, input int vd, input logic al, input int tail);
    push_entry(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
    push_entry(4'b0000, 1'b1, 3'd1, 1'b0, 1'b0);
    if (hd != 0) begin push_move(0, hd, 8); push_settle(); end
    if (vd != 0) begin push_move(1, vd, 8); push_settle(); end
    push_entry(4'b0000, 1'b0, 3'd0, 1'b1, al);
    for (int i = 0; i < tail; i++) push_entry(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Compare the current cycle at the falling edge, then advance to just after
  // the next rising edge where the caller drives the following cycle's inputs.
  task automatic checkOutput();
    exp_t       e;
    logic [3:0] outs;
    @(negedge CLK);
    outs = {h_cw, h_ccw, v_cw, v_ccw};
    checks++;
    if ($countones(outs) > 1) begin
      errors++;
      $display("[TB] FAIL onehot %s cyc %0d: outs=%b, at most one bit allowed", cur_name, cyc, outs);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({outs, busy, state} !== {e.o, e.b, e.s}) begin
        errors++;
        $display("[TB] FAIL timeline %s cyc %0d: got outs=%b busy=%b state=%0d, expected outs=%b busy=%b state=%0d",
                 cur_name, cyc, outs, busy, state, e.o, e.b, e.s);
      end
      if (e.ca) begin
        checks++;
        if (aligned !== e.al) begin
          errors++;
          $display("[TB] FAIL aligned %s cyc %0d: got %b, expected %b", cur_name, cyc, aligned, e.al);
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int budget = 100;
    while (exp_q.size() > 0 && budget > 0) begin
      checkOutput();
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain %s: %0d expectations left, expected 0", cur_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_frame(input vec_t v);
    cur_name = v.name;
    {ldr_tl, ldr_tr, ldr_bl, ldr_br} = {v.tl, v.tr, v.bl, v.br};
    pos_h = v.ph;
    pos_v = v.pv;
    sample_valid = 1'b1;
    cyc = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    load_frame(v);
    push_timeline(v.hd, v.vd, v.al, 1);
    checkOutput();
    sample_valid = 1'b0;
    drain();
  endtask

  initial begin
    // tl, tr, bl, br, pos_h, pos_v, h dir, v dir (0 stop, 1 cw, 2 ccw), aligned
    vecs[0] = '{1000, 1000, 1000, 1000, 1500, 1500, 0, 0, 1'b1, "centered"};
    vecs[1] = '{1000, 1100, 1000, 1100, 1500, 1500, 1, 0, 1'b0, "right"};
    vecs[2] = '{1200, 1000, 1000, 1000, 1500, 1500, 2, 1, 1'b0, "both"};
    vecs[3] = '{1000, 1100, 1000, 1100, 2400, 1500, 0, 0, 1'b1, "h_at_max"};
    vecs[4] = '{1000, 1032, 1000, 1032, 1500, 1500, 0, 0, 1'b1, "dh64"};
    vecs[5] = '{1000, 1033, 1000, 1032, 1500, 1500, 1, 0, 1'b0, "dh65"};
    vecs[6] = '{1000, 1000, 1033, 1032, 1500, 1500, 0, 2, 1'b0, "dv_m65"};
    vecs[7] = '{1033, 1000, 1032, 1000,  600, 1500, 0, 0, 1'b1, "h_at_min"};
    vecs[8] = '{4095, 4095,    0,    0, 1500, 1500, 0, 1, 1'b0, "dv_full"};

    repeat (2) @(posedge CLK);
    #1;
    push_entry(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput();
    RST = 1'b0;
    push_entry(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput();

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Limit abort: pos_h reaches POS_MAX in the third move cycle.
    load_frame(vecs[1]);
    cur_name = "limit_abort";
    push_entry(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
    push_entry(4'b0000, 1'b1, 3'd1, 1'b0, 1'b0);
    push_move(0, 1, 3);
    push_settle();
    push_entry(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput();
    sample_valid = 1'b0;
    repeat (3) checkOutput();
    pos_h = 32'd2400;
    drain();
    pos_h = 32'd1500;

    // sample_valid during SETTLE and on the cycle of return to IDLE is ignored.
    load_frame(vecs[1]);
    cur_name = "settle_ignore";
    push_timeline(1, 0, 1'b0, 2);
    checkOutput();
    sample_valid = 1'b0;
    repeat (10) checkOutput();
    ldr_tl = 12'd1200;
    sample_valid = 1'b1;
    checkOutput();
    sample_valid = 1'b0;
    checkOutput();
    sample_valid = 1'b1;
    checkOutput();
    sample_valid = 1'b0;
    drain();

    // Next pulse after that is accepted and leaves aligned set for the reset case.
    applyStimulus(vecs[0]);

    // Reset in the middle of a vertical move.
    load_frame(vecs[6]);
    cur_name = "reset_mid_move";
    push_entry(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
    push_entry(4'b0000, 1'b1, 3'd1, 1'b0, 1'b0);
    push_move(1, 2, 4);
    push_entry(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput();
    sample_valid = 1'b0;
    repeat (4) checkOutput();
    RST = 1'b1;
    checkOutput();
    RST = 1'b0;
    drain();

    applyStimulus(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
